// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared defaults, state type and counter limit for the memory responder
`ifndef WIDTH
`define WIDTH 8
`endif
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 4
`endif

package mem_pkg;
   localparam int WIDTH_DEF      = `WIDTH;
   localparam int ADDR_WIDTH_DEF = `ADDR_WIDTH;
   localparam int DEPTH_DEF      = 2 ** `ADDR_WIDTH;
   localparam int CNT_WIDTH_DEF  = 16;

   // All-ones pattern wide enough for any counter up to 64 bits; truncated per instance.
   localparam logic [63:0] CNT_SAT = '1;

   typedef enum logic {
      INIT = 1'b0,
      RUN  = 1'b1
   } state_t;
endpackage

// File: rtl/mem_array.sv
// rtl/mem_array.sv - DEPTH x WIDTH storage, one synchronous write port and one synchronous read port
module mem_array #(
   parameter int WIDTH      = 8,
   parameter int ADDR_WIDTH = 4,
   parameter int DEPTH      = 16
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [ADDR_WIDTH-1:0] waddr,
   input  logic [WIDTH-1:0]      wdata,
   input  logic                  re,
   input  logic [ADDR_WIDTH-1:0] raddr,
   output logic [WIDTH-1:0]      rdata
);
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] rdata_q, rdata_d;

   // Take the addressed word only on a read request; otherwise hold the last word.
   always_comb begin
      rdata_d = rdata_q;
      if (re) begin
         rdata_d = mem_q[raddr];
      end
   end

   // Storage and read register; no reset, contents are cleared by the responder's zero-fill.
   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[waddr] <= wdata;
      end
      rdata_q <= rdata_d;
   end

   assign rdata = rdata_q;
endmodule

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - valid/ready memory responder with zero-fill, reject logic and transfer counters
module mem_responder
   import mem_pkg::*;
#(
   parameter int WIDTH      = WIDTH_DEF,
   parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
   parameter int DEPTH      = DEPTH_DEF,
   parameter int CNT_WIDTH  = CNT_WIDTH_DEF
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  valid,
   input  logic                  wr_rd,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [WIDTH-1:0]      wdata,
   output logic                  ready,
   output logic [WIDTH-1:0]      rdata,
   output logic                  error,
   output logic                  init_done,
   output logic [CNT_WIDTH-1:0]  wr_count,
   output logic [CNT_WIDTH-1:0]  rd_count
);
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
   localparam logic [ADDR_WIDTH:0]   DEPTH_W   = (ADDR_WIDTH + 1)'(DEPTH);
   localparam logic [CNT_WIDTH-1:0]  CNT_MAX   = CNT_WIDTH'(CNT_SAT);

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
   logic                  valid_q, valid_d;
   logic                  err_q, err_d;
   logic                  rd_ok_q, rd_ok_d;
   logic [CNT_WIDTH-1:0]  wr_cnt_q, wr_cnt_d;
   logic [CNT_WIDTH-1:0]  rd_cnt_q, rd_cnt_d;

   logic                  accept;
   logic                  mem_we;
   logic                  mem_re;
   logic [ADDR_WIDTH-1:0] mem_waddr;
   logic [WIDTH-1:0]      mem_wdata;
   logic [WIDTH-1:0]      mem_rdata;

   // FSM state and zero-fill pointer
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= INIT;
         ptr_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
      end
   end

   // Walk the pointer through every word once, then stay in RUN until reset
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      case (state_q)
         INIT: begin
            ptr_d = ptr_q + 1'b1;
            if (ptr_q == LAST_ADDR) begin
               state_d = RUN;
               ptr_d   = '0;
            end
         end
         RUN:     state_d = RUN;
         default: state_d = INIT;
      endcase
   end

   // FSM outputs: zero-fill owns the write port in INIT, accepted writes own it in RUN
   always_comb begin
      init_done = (state_q == RUN);
      accept    = valid && (state_q == RUN) && ({1'b0, addr} < DEPTH_W);
      mem_re    = accept && !wr_rd;
      mem_we    = accept && wr_rd;
      mem_waddr = addr;
      mem_wdata = wdata;
      if (state_q == INIT) begin
         mem_we    = 1'b1;
         mem_waddr = ptr_q;
         mem_wdata = '0;
      end
   end

   // Completion status for next cycle and saturating transfer counters
   always_comb begin
      valid_d  = valid;
      err_d    = valid && !accept;
      rd_ok_d  = mem_re;
      wr_cnt_d = wr_cnt_q;
      rd_cnt_d = rd_cnt_q;
      if (mem_we && (state_q == RUN) && (wr_cnt_q != CNT_MAX)) begin
         wr_cnt_d = wr_cnt_q + 1'b1;
      end
      if (mem_re && (rd_cnt_q != CNT_MAX)) begin
         rd_cnt_d = rd_cnt_q + 1'b1;
      end
   end

   // Pipeline and counter registers; reset drops any in-flight completion
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         valid_q  <= 1'b0;
         err_q    <= 1'b0;
         rd_ok_q  <= 1'b0;
         wr_cnt_q <= '0;
         rd_cnt_q <= '0;
      end else begin
         valid_q  <= valid_d;
         err_q    <= err_d;
         rd_ok_q  <= rd_ok_d;
         wr_cnt_q <= wr_cnt_d;
         rd_cnt_q <= rd_cnt_d;
      end
   end

   mem_array #(
      .WIDTH      (WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH),
      .DEPTH      (DEPTH)
   ) u_mem_array (
      .clk   (clk),
      .we    (mem_we),
      .waddr (mem_waddr),
      .wdata (mem_wdata),
      .re    (mem_re),
      .raddr (addr),
      .rdata (mem_rdata)
   );

   assign ready    = valid_q;
   assign error    = err_q;
   assign rdata    = rd_ok_q ? mem_rdata : '0;
   assign wr_count = wr_cnt_q;
   assign rd_count = rd_cnt_q;
endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory responder (slave) for the team's single-channel valid/ready memory protocol: the other end of the initiator that drives wr_rd/addr/wdata/valid.
- Holds a DEPTH x WIDTH storage array and completes one transfer per cycle.
- Ready is returned exactly one cycle after each valid cycle.
- After reset, zero-fills the array with an init state machine. Provides error and transfer-count status for the testbench and the protocol checker.

Parameters:
- WIDTH, 8, data width in bits (`WIDTH)
- ADDR_WIDTH, 4, address width in bits (`ADDR_WIDTH)
- DEPTH, 16, number of words; 1 <= DEPTH <= 2**ADDR_WIDTH
- CNT_WIDTH, 16, width of the transfer counters

Ports:
- clk  input  1  single clock; all logic on the rising edge
- rst  input  1  asynchronous, active-low reset (0 = reset)
- valid  input  1  initiator request; one transfer per cycle in which it is high
- wr_rd  input  1  1 = write, 0 = read; sampled with valid
- addr  input  ADDR_WIDTH  word address; sampled with valid
- wdata  input  WIDTH  write data; sampled with valid when wr_rd=1
- ready  output  1  completion strobe; high the cycle after each valid cycle
- rdata  output  WIDTH  read data; meaningful only with ready after a read, 0 otherwise
- error  output  1  qualifies ready; the transfer was rejected
- init_done  output  1  high once the zero-fill is complete
- wr_count  output  CNT_WIDTH  number of successful writes
- rd_count  output  CNT_WIDTH  number of successful reads

Behaviour:
- Reset (rst=0, async): outputs go to ready=0, rdata=0, error=0, init_done=0, wr_count=0, rd_count=0; the FSM goes to INIT with init pointer=0. Array contents are not reset directly.
- Reset asserted mid-operation: any in-flight completion is dropped (no ready pulse) and the zero-fill restarts.
- FSM INIT:
  - Writes 0 to address ptr each cycle; ptr increments.
  - At ptr==DEPTH-1 the FSM goes to RUN, and init_done=1 from the next cycle.
  - Init takes exactly DEPTH cycles after reset release.
- FSM RUN: remains in RUN until reset.
- Pipeline registers: every cycle, valid_q<=valid, wr_q<=wr_rd, and addr/wdata are captured. ready = valid_q, which gives latency 1 with no stall.
- Every valid cycle produces a ready in the next cycle, including back-to-back cycles: valid held high for N cycles gives N ready cycles, shifted by 1.
- Reject conditions (error=1 with that ready):
  - valid in INIT, or
  - addr >= DEPTH.
  - A rejected transfer does not change the array or the counters, and rdata=0.
- Write (accepted): the array is updated at the edge that ends the valid cycle; rdata=0 during the ready cycle; wr_count+1.
- Read (accepted): rdata = array[addr] during the ready cycle, registered, so it reflects a write accepted in the immediately preceding cycle. rd_count+1.
- Read-after-write to the same address in consecutive valid cycles returns the new data; no bypass hazard.
- rdata=0 and error=0 whenever ready=0.
- Counters saturate at all-ones; they do not wrap.
- No X on any output after reset release. Each output is either driven from reset or driven to 0 when not qualified.

Decomposition:
- Shared package mem_pkg:
  - WIDTH/ADDR_WIDTH/DEPTH defaults matching the `WIDTH/`ADDR_WIDTH macros
  - state typedef enum {INIT, RUN}
  - localparam for the counter saturation value
- One natural sub-module, mem_array: a synchronous-write, synchronous-read DEPTH x WIDTH storage with a single write port and a single read port, no reset. The responder contains the FSM, the pipeline registers, the reject logic and the counters.

Test Plan:
- Reset then idle: rst=0 for 3 cycles, then release -> all outputs 0; init_done rises exactly DEPTH(16) cycles after release.
- Write/read: after init, write addr=3 wdata=8'hA5 with 1 valid cycle, then read addr=3 -> ready the cycle after each valid; read rdata=8'hA5; wr_count=1, rd_count=1, error=0.
- Back-to-back: valid high 4 cycles (W 5=8'h11, R 5, W 5=8'h22, R 5) -> ready high 4 consecutive cycles; rdata 0, 8'h11, 0, 8'h22.
- Errors: with DEPTH=12, read addr=13 -> ready=1, error=1, rdata=0, rd_count unchanged. Valid during INIT -> ready=1, error=1.
- Init clear: write addr=7=8'hFF, pulse rst low mid-transfer, wait init_done, read addr=7 -> rdata=0, counters=0, no ready for the aborted transfer.
- Saturation: CNT_WIDTH=2, 5 writes -> wr_count stays 2'b11.
